aud_recorder: RTL and testbench
===============================

AUD_RECORDER -- requirements
Module: aud_recorder

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, sample width in bits.
REQ-003 SHALL have port i_bclk  input  1  codec bit clock, the only clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_adclrck  input  1  codec ADC LR clock; low = left channel, high = right channel.
REQ-006 SHALL have port i_aud_adcdat  input  1  codec serial ADC data, MSB first, I2S (one-bclk delay after LRCK edge).
REQ-007 SHALL have ports i_start, i_pause, i_stop  input  1 each  single-cycle control pulses.
REQ-008 SHALL have port o_we  output  1  write strobe, one cycle per captured sample.
REQ-009 SHALL have port o_address  output  ADDR_W  write address, valid while o_we=1.
REQ-010 SHALL have port o_data  output  DATA_W  captured sample, valid while o_we=1.
REQ-011 SHALL have ports o_full  output  1  sticky memory-full flag; o_busy  output  1  high in any state except IDLE.

Function
REQ-012 SHALL implement states IDLE, WAIT_LRC, RECV, WRITE, PAUSE.
REQ-013 IDLE: i_start -> clear o_address to 0, clear o_full, go WAIT_LRC; all other inputs ignored.
REQ-014 WAIT_LRC: falling edge of i_adclrck (registered previous value 1, current value 0) -> RECV with bit counter 0.
REQ-015 RECV: SHALL sample i_aud_adcdat on the 16 rising edges following the edge-detect edge, MSB first, shifting left.
REQ-016 After the 16th bit, SHALL enter WRITE; o_we=1 and o_data=the assembled word for exactly one cycle (latency of 1 cycle from the LSB sample).
REQ-017 In the cycle after WRITE, o_address SHALL increment by 1, and the block SHALL return to WAIT_LRC.
REQ-018 Write at o_address = 2^ADDR_W-1 SHALL set o_full and go IDLE; o_address SHALL hold at 2^ADDR_W-1 with no wrap.
REQ-019 i_pause in WAIT_LRC -> PAUSE; in RECV/WRITE SHALL be latched and take effect after the current word is written.
REQ-020 PAUSE: i_start -> WAIT_LRC (o_address retained); i_stop -> IDLE.
REQ-021 i_stop in any non-IDLE state SHALL go IDLE next cycle; a partial word SHALL be discarded (no o_we); o_address SHALL keep the count of samples written.
REQ-022 Simultaneous pulses: stop > pause > start priority.
REQ-023 o_we SHALL be 0 in all states except WRITE; o_data SHALL hold its last value otherwise.

Reset
REQ-024 i_rst_n low SHALL immediately force IDLE, o_we=0, o_address=0, o_data=0, o_full=0, o_busy=0, and clear the shift register, bit counter, pause latch and LRC history, including mid-word.

Configuration
REQ-025 Macro AUD_REC_STEREO_EN defined: rising edge of i_adclrck SHALL also start capture; right samples SHALL be written at the address following the left, with one o_we each.
REQ-026 Macro AUD_REC_STEREO_EN undefined: only the left channel (falling edge) SHALL be captured; the rising edge SHALL be ignored.

Structure
REQ-027 Package aud_pkg SHALL hold the state enum, DATA_W/ADDR_W defaults and the I2S bit-count constant (16), shared with the player.
REQ-028 One sub-module, aud_lrc_edge (LRC register plus rise/fall pulses), SHALL be instantiated; the FSM and datapath stay in aud_recorder.

Verification
REQ-029 Reset, start, one left frame carrying 16'hBA0E -> o_we single pulse, o_data=16'hBA0E, o_address=0, o_we exactly 17 edges after edge detect.
REQ-030 Four frames 16'hBA0E, 16'h5E3A, 16'hEA19, 16'hF815 -> addresses 0..3 written in order, o_address=4 after stop.
REQ-031 Pause at bit 8 of the 2nd word -> word completes and is written at address 1, no writes during 3 paused frames, start resumes at address 2.
REQ-032 Stop at bit 5 -> no o_we, IDLE next cycle, o_busy=0; i_rst_n pulse mid-word -> all outputs 0 immediately.
REQ-033 ADDR_W=4, 17 frames -> 16 writes, o_full=1 after address 15, 17th frame ignored; restart clears o_full.
REQ-034 With AUD_REC_STEREO_EN, L=16'h1234, R=16'hABCD -> writes at addresses 0 and 1 in that order.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared definitions for the audio recorder and player.
//   AudAddrW / AudDataW : default SRAM word-address and sample widths
//   I2sBits             : data bits per I2S channel slot
//   aud_state_e         : recorder FSM state encoding
package aud_pkg;

  localparam int unsigned AudAddrW = 20;
  localparam int unsigned AudDataW = 16;
  localparam int unsigned I2sBits  = 16;
  // Wide enough to hold the value I2sBits itself (terminal count).
  localparam int unsigned BitCntW  = $clog2(I2sBits + 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitLrc,
    StRecv,
    StWrite,
    StPause
  } aud_state_e;

endpackage

// File: rtl/aud_lrc_edge.sv
// LRC edge detector: registers the codec LR clock once and flags the
// change between the registered (previous) and current value.
//   clk_i   : codec bit clock
//   rst_ni  : asynchronous active-low reset, clears the LRC history
//   lrc_i   : codec ADC LR clock
//   rise_o  : previous 0, current 1 (start of right channel)
//   fall_o  : previous 1, current 0 (start of left channel)
module aud_lrc_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic lrc_i,
  output logic rise_o,
  output logic fall_o
);

  logic lrc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lrc_q <= 1'b0;
    end else begin
      lrc_q <= lrc_i;
    end
  end

  assign rise_o = lrc_i & ~lrc_q;
  assign fall_o = ~lrc_i & lrc_q;

endmodule

// File: rtl/aud_recorder.sv
// I2S audio recorder: deserialises codec ADC samples and writes them to
// consecutive SRAM word addresses.
//   i_bclk, i_rst_n        : bit clock (rising edge) and async active-low reset
//   i_adclrck, i_aud_adcdat: codec LR clock and serial data (I2S, MSB first)
//   i_start/i_pause/i_stop : single-cycle controls, priority stop > pause > start
//   o_we, o_address, o_data: one-cycle write strobe with address and sample
//   o_full                 : sticky, set after writing the last address
//   o_busy                 : high whenever not idle
// Build option: define AUD_REC_STEREO_EN to also capture the right channel
// (LRC rising edge); otherwise only the left channel is recorded.
module aud_recorder
  import aud_pkg::*;
#(
  parameter int unsigned ADDR_W = AudAddrW,
  parameter int unsigned DATA_W = AudDataW
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_adclrck,
  input  logic              i_aud_adcdat,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_busy
);

  aud_state_e         state_q, state_d;
  logic [BitCntW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               pause_q, pause_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               full_q, full_d;

  logic lrc_rise;
  logic lrc_fall;
  logic capture_start;

  aud_lrc_edge u_lrc_edge (
    .clk_i  (i_bclk),
    .rst_ni (i_rst_n),
    .lrc_i  (i_adclrck),
    .rise_o (lrc_rise),
    .fall_o (lrc_fall)
  );

`ifdef AUD_REC_STEREO_EN
  assign capture_start = lrc_fall | lrc_rise;
`else
  assign capture_start = lrc_fall;
  logic unused_rise;
  assign unused_rise = lrc_rise;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    pause_d = pause_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    full_d  = full_q;

    unique case (state_q)
      StIdle: begin
        if (i_start && !i_stop) begin
          addr_d  = '0;
          full_d  = 1'b0;
          pause_d = 1'b0;
          state_d = StWaitLrc;
        end
      end

      StWaitLrc: begin
        if (i_stop) begin
          pause_d = 1'b0;
          state_d = StIdle;
        end else if (i_pause) begin
          state_d = StPause;
        end else if (capture_start) begin
          cnt_d   = '0;
          shift_d = '0;
          state_d = StRecv;
        end
      end

      StRecv: begin
        if (i_stop) begin
          // Partial word is dropped; address keeps the count already written.
          pause_d = 1'b0;
          state_d = StIdle;
        end else begin
          if (i_pause) begin
            pause_d = 1'b1;
          end
          if (cnt_q == BitCntW'(I2sBits)) begin
            // All bits in: present the word with the strobe next cycle.
            we_d    = 1'b1;
            data_d  = shift_q;
            state_d = StWrite;
          end else begin
            shift_d = {shift_q[DATA_W-2:0], i_aud_adcdat};
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end

      StWrite: begin
        // The write is happening this cycle, so the address advances even on stop.
        if (addr_q == {ADDR_W{1'b1}}) begin
          full_d  = 1'b1;
          pause_d = 1'b0;
          state_d = StIdle;
        end else begin
          addr_d = addr_q + 1'b1;
          if (i_stop) begin
            pause_d = 1'b0;
            state_d = StIdle;
          end else if (pause_q || i_pause) begin
            pause_d = 1'b0;
            state_d = StPause;
          end else begin
            state_d = StWaitLrc;
          end
        end
      end

      StPause: begin
        if (i_stop) begin
          state_d = StIdle;
        end else if (!i_pause && i_start) begin
          state_d = StWaitLrc;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      pause_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      pause_q <= pause_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      full_q  <= full_d;
    end
  end

  assign o_we      = we_q;
  assign o_address = addr_q;
  assign o_data    = data_q;
  assign o_full    = full_q;
  assign o_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_aud_recorder.sv
// Directed bench for aud_recorder. A 20-bit instance carries the main tests;
// a 4-bit-address instance shares the stimulus to exercise the full flag.
module tb_aud_recorder;

  logic        bclk = 1'b0;
  logic        rst_n;
  logic        lrc;
  logic        dat;
  logic        start;
  logic        pause;
  logic        stop;

  logic        we;
  logic [19:0] addr;
  logic [15:0] data;
  logic        full;
  logic        busy;

  logic        s_we;
  logic [3:0]  s_addr;
  logic [15:0] s_data;
  logic        s_full;
  logic        s_busy;

  always #5 bclk = ~bclk;

  aud_recorder dut (
    .i_bclk       (bclk),
    .i_rst_n      (rst_n),
    .i_adclrck    (lrc),
    .i_aud_adcdat (dat),
    .i_start      (start),
    .i_pause      (pause),
    .i_stop       (stop),
    .o_we         (we),
    .o_address    (addr),
    .o_data       (data),
    .o_full       (full),
    .o_busy       (busy)
  );

  aud_recorder #(
    .ADDR_W (4)
  ) dut_s (
    .i_bclk       (bclk),
    .i_rst_n      (rst_n),
    .i_adclrck    (lrc),
    .i_aud_adcdat (dat),
    .i_start      (start),
    .i_pause      (pause),
    .i_stop       (stop),
    .o_we         (s_we),
    .o_address    (s_addr),
    .o_data       (s_data),
    .o_full       (s_full),
    .o_busy       (s_busy)
  );

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
    int          slot;
  } wr_t;

  typedef struct {
    logic [15:0] word;
    logic [19:0] exp_addr;
    int          exp_slot;
  } vec_t;

  wr_t         wq[$];
  int          s_cnt;
  logic [3:0]  s_last;
  int          cur_slot;
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for a rising edge, record any write strobes, then drive the next inputs.
  task automatic step(input logic l, input logic d, input logic st, input logic pa,
                      input logic sp);
    wr_t w;
    @(posedge bclk);
    #1;
    if (we === 1'b1) begin
      w.addr = addr;
      w.data = data;
      w.slot = cur_slot;
      wq.push_back(w);
    end
    if (s_we === 1'b1) begin
      s_cnt++;
      s_last = s_addr;
    end
    lrc   = l;
    dat   = d;
    start = st;
    pause = pa;
    stop  = sp;
  endtask

  task automatic idle(input int n, input logic st);
    for (int i = 0; i < n; i++) begin
      cur_slot = -1;
      step(1'b1, 1'b0, (i == 0) ? st : 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One 64-bclk I2S frame: slot 0 drops LRC, left MSB in slot 1, right MSB in
  // slot 33. pulse = {stop, pause, start} driven for one cycle at slot pslot.
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int pslot,
                            input logic [2:0] pulse);
    for (int k = 0; k < 64; k++) begin
      logic       lv;
      logic       dv;
      logic [2:0] p;
      lv = (k >= 32);
      dv = 1'b0;
      if (k >= 1 && k <= 16) dv = l[16-k];
      else if (k >= 33 && k <= 48) dv = r[48-k];
      p = (k == pslot) ? pulse : 3'b000;
      cur_slot = k;
      step(lv, dv, p[0], p[1], p[2]);
    end
  endtask

  task automatic do_reset();
    @(negedge bclk);
    rst_n = 1'b0;
    lrc   = 1'b1;
    dat   = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
    repeat (3) @(negedge bclk);
    rst_n = 1'b1;
    idle(2, 1'b0);
  endtask

  vec_t vecs[4];

  initial begin
    logic [15:0] w;
    checks = 0;
    errors = 0;
    s_cnt  = 0;
    s_last = '0;
    cur_slot = -1;

    vecs[0] = '{16'hBA0E, 20'd0, 18};
    vecs[1] = '{16'h5E3A, 20'd1, 18};
    vecs[2] = '{16'hEA19, 20'd2, 18};
    vecs[3] = '{16'hF815, 20'd3, 18};

    rst_n = 1'b0;
    lrc   = 1'b1;
    dat   = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
    #23;
    chk("reset_we", {31'd0, we}, 32'd0);
    chk("reset_addr", {12'd0, addr}, 32'd0);
    chk("reset_data", {16'd0, data}, 32'd0);
    chk("reset_full", {31'd0, full}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(2, 1'b0);

`ifdef AUD_REC_STEREO_EN
    idle(1, 1'b1);
    wq.delete();
    send_frame(16'h1234, 16'hABCD, -1, 3'b000);
    chk("stereo_count", wq.size(), 32'd2);
    if (wq.size() == 2) begin
      chk("stereo_l_addr", {12'd0, wq[0].addr}, 32'd0);
      chk("stereo_l_data", {16'd0, wq[0].data}, 32'h1234);
      chk("stereo_l_slot", wq[0].slot, 32'd18);
      chk("stereo_r_addr", {12'd0, wq[1].addr}, 32'd1);
      chk("stereo_r_data", {16'd0, wq[1].data}, 32'hABCD);
      chk("stereo_r_slot", wq[1].slot, 32'd50);
    end
    chk("stereo_addr_after", {12'd0, addr}, 32'd2);
`else
    // Four frames from the vector table; right channel must be ignored.
    idle(1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wq.delete();
      send_frame(vecs[i].word, ~vecs[i].word, -1, 3'b000);
      chk($sformatf("vec%0d_count", i), wq.size(), 32'd1);
      if (wq.size() >= 1) begin
        chk($sformatf("vec%0d_addr", i), {12'd0, wq[0].addr}, {12'd0, vecs[i].exp_addr});
        chk($sformatf("vec%0d_data", i), {16'd0, wq[0].data}, {16'd0, vecs[i].word});
        chk($sformatf("vec%0d_slot", i), wq[0].slot, vecs[i].exp_slot);
      end
      chk($sformatf("vec%0d_addr_after", i), {12'd0, addr}, {12'd0, vecs[i].exp_addr} + 32'd1);
    end
    cur_slot = -1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_addr", {12'd0, addr}, 32'd4);

    // Pause mid-word: word still written, then no writes until restart.
    idle(1, 1'b1);
    send_frame(16'h1111, 16'h0000, -1, 3'b000);
    wq.delete();
    send_frame(16'h2222, 16'h0000, 8, 3'b010);
    chk("pause_count", wq.size(), 32'd1);
    if (wq.size() >= 1) begin
      chk("pause_wr_addr", {12'd0, wq[0].addr}, 32'd1);
      chk("pause_wr_data", {16'd0, wq[0].data}, 32'h2222);
    end
    chk("pause_busy", {31'd0, busy}, 32'd1);
    chk("pause_addr", {12'd0, addr}, 32'd2);
    wq.delete();
    for (int i = 0; i < 3; i++) send_frame(16'h3333, 16'h4444, -1, 3'b000);
    chk("paused_no_we", wq.size(), 32'd0);
    chk("paused_addr", {12'd0, addr}, 32'd2);
    idle(1, 1'b1);
    wq.delete();
    send_frame(16'hC0DE, 16'h0000, -1, 3'b000);
    chk("resume_count", wq.size(), 32'd1);
    if (wq.size() >= 1) begin
      chk("resume_addr", {12'd0, wq[0].addr}, 32'd2);
      chk("resume_data", {16'd0, wq[0].data}, 32'hC0DE);
    end

    // Stop at bit 5: partial word dropped, idle on the next cycle.
    wq.delete();
    w = 16'hFFFF;
    for (int k = 0; k < 64; k++) begin
      cur_slot = k;
      step(k >= 32, (k >= 1 && k <= 16) ? w[16-k] : 1'b0, 1'b0, 1'b0, k == 5);
      if (k == 6) chk("stop_mid_busy", {31'd0, busy}, 32'd0);
    end
    chk("stop_mid_no_we", wq.size(), 32'd0);
    chk("stop_mid_addr", {12'd0, addr}, 32'd3);
    chk("stop_mid_data", {16'd0, data}, 32'hC0DE);

    // Async reset mid-word clears outputs without waiting for a clock edge.
    idle(1, 1'b1);
    send_frame(16'h7E57, 16'h0000, -1, 3'b000);
    w = 16'hA5A5;
    for (int k = 0; k <= 10; k++) begin
      cur_slot = k;
      step(1'b0, (k >= 1) ? w[16-k] : 1'b0, 1'b0, 1'b0, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we", {31'd0, we}, 32'd0);
    chk("arst_addr", {12'd0, addr}, 32'd0);
    chk("arst_data", {16'd0, data}, 32'd0);
    chk("arst_full", {31'd0, full}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    #10;
    rst_n = 1'b1;
    idle(3, 1'b0);

    // Full flag on the 4-bit instance: 16 writes, 17th frame ignored.
    do_reset();
    idle(1, 1'b1);
    s_cnt = 0;
    for (int i = 0; i < 17; i++) send_frame(16'h0100 + 16'(i), 16'h0000, -1, 3'b000);
    chk("full_wr_count", s_cnt, 32'd16);
    chk("full_last_addr", {28'd0, s_last}, 32'd15);
    chk("full_flag", {31'd0, s_full}, 32'd1);
    chk("full_addr_hold", {28'd0, s_addr}, 32'd15);
    chk("full_idle", {31'd0, s_busy}, 32'd0);
    chk("full_data", {16'd0, s_data}, 32'h010F);
    chk("big_not_full", {31'd0, full}, 32'd0);
    chk("big_addr", {12'd0, addr}, 32'd17);
    idle(2, 1'b1);
    chk("restart_full", {31'd0, s_full}, 32'd0);
    chk("restart_addr", {28'd0, s_addr}, 32'd0);
    chk("restart_busy", {31'd0, s_busy}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
